// File: rtl/uop_issue_queue_if.sv
// Decode-to-backend handshake bundle for the uop issue queue.
// The queue takes the slave side; decode and the backend RAT drive the master side.
interface uop_issue_queue_if #(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 4,
    parameter int UOP_BITS  = 128
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ENQ_WIDTH-1:0]          enq_valid_in;
    logic [ENQ_WIDTH*UOP_BITS-1:0] enq_uops_in;
    logic                          enq_ready_out;
    logic                          q_valid_out;
    logic [DEQ_WIDTH-1:0]          q_lane_valid_out;
    logic [DEQ_WIDTH*UOP_BITS-1:0] q_uops_out;
    logic                          q_increment_ready_in;
    logic [CNT_W-1:0]              count_out;

    modport master (
        output enq_valid_in,
        output enq_uops_in,
        output q_increment_ready_in,
        input  enq_ready_out,
        input  q_valid_out,
        input  q_lane_valid_out,
        input  q_uops_out,
        input  count_out
    );

    modport slave (
        input  enq_valid_in,
        input  enq_uops_in,
        input  q_increment_ready_in,
        output enq_ready_out,
        output q_valid_out,
        output q_lane_valid_out,
        output q_uops_out,
        output count_out
    );
endinterface

// File: rtl/uop_issue_queue.sv
// Decoupling FIFO between decode and rename: compacts up to ENQ_WIDTH uops per cycle
// and presents the oldest DEQ_WIDTH entries as one group, flushed on mispredict.
module uop_issue_queue #(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 4,
    parameter int UOP_BITS  = 128
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    uop_issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ENQ_C   = CNT_W'(ENQ_WIDTH);
    localparam logic [CNT_W-1:0] DEQ_C   = CNT_W'(DEQ_WIDTH);

    logic [UOP_BITS-1:0] r_storage [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic [CNT_W-1:0]    w_free;
    logic                w_enqReady;
    logic                w_qValid;
    logic                w_enqFire;
    logic                w_deqFire;
    logic [CNT_W-1:0]    w_enqCount;
    logic [CNT_W-1:0]    w_deqCount;
    logic [CNT_W-1:0]    w_enqAdd;
    logic [CNT_W-1:0]    w_deqSub;
    logic [PTR_W-1:0]    w_laneOffset [ENQ_WIDTH];

    // Readiness looks only at registered occupancy, so a same-cycle pop never helps.
    assign w_free     = DEPTH_C - r_count;
    assign w_enqReady = (w_free >= ENQ_C);
    assign w_qValid   = (r_count != '0);
    assign w_enqFire  = w_enqReady && (|bus.enq_valid_in) && !flush_in;
    assign w_deqFire  = w_qValid && bus.q_increment_ready_in && !flush_in;
    assign w_deqCount = (r_count < DEQ_C) ? r_count : DEQ_C;
    assign w_enqAdd   = w_enqFire ? w_enqCount : '0;
    assign w_deqSub   = w_deqFire ? w_deqCount : '0;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        w_enqCount = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            w_laneOffset[i] = w_enqCount[PTR_W-1:0];
            w_enqCount      = w_enqCount + CNT_W'(bus.enq_valid_in[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (w_enqFire && bus.enq_valid_in[i]) begin
                r_storage[r_tail + w_laneOffset[i]] <= bus.enq_uops_in[i*UOP_BITS +: UOP_BITS];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deqSub[PTR_W-1:0];
            r_tail  <= r_tail + w_enqAdd[PTR_W-1:0];
            r_count <= r_count + w_enqAdd - w_deqSub;
        end
    end

    assign bus.enq_ready_out = w_enqReady;
    assign bus.q_valid_out   = w_qValid;
    assign bus.count_out     = r_count;

    for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_lane
        assign bus.q_lane_valid_out[g]                = (CNT_W'(g) < r_count);
        assign bus.q_uops_out[g*UOP_BITS +: UOP_BITS] = r_storage[r_head + PTR_W'(g)];
    end
endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed bench for uop_issue_queue: hand-computed checkpoints plus a FIFO model
// that tracks which uops must be presented and in what order.
module tb_uop_issue_queue;
    localparam int DEPTH     = 16;
    localparam int ENQ_WIDTH = 4;
    localparam int DEQ_WIDTH = 4;
    localparam int UOP_BITS  = 128;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int nextId     = 1;

    logic [UOP_BITS-1:0] model [$];
    logic [UOP_BITS-1:0] sent [ENQ_WIDTH];
    logic [UOP_BITS-1:0] savedA;
    logic [UOP_BITS-1:0] savedB;

    always #5 clk = ~clk;

    uop_issue_queue_if #(
        .DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .DEQ_WIDTH(DEQ_WIDTH), .UOP_BITS(UOP_BITS)
    ) bus ();

    uop_issue_queue #(
        .DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .DEQ_WIDTH(DEQ_WIDTH), .UOP_BITS(UOP_BITS)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .flush_in (flush),
        .bus      (bus.slave)
    );

    function automatic logic [UOP_BITS-1:0] makeUop(int id);
        logic [31:0] v;
        v = 32'(id);
        return {v, 32'hC0DE_0000 | v, ~v, 32'h5A5A_0000 + v};
    endfunction

    task automatic checkOutput(string tag, logic [UOP_BITS-1:0] got, logic [UOP_BITS-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the model the way the queue should, then
    // returns #1 after the active edge with the inputs idled again.
    task automatic applyStimulus(logic [ENQ_WIDTH-1:0] mask, logic deq, logic fl);
        int  m;
        bit  ready;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            sent[i] = makeUop(nextId);
            nextId++;
            bus.enq_uops_in[i*UOP_BITS +: UOP_BITS] = sent[i];
        end
        bus.enq_valid_in         = mask;
        bus.q_increment_ready_in = deq;
        flush                    = fl;
        if (fl) begin
            model.delete();
        end else begin
            ready = (DEPTH - model.size()) >= ENQ_WIDTH;
            if (deq && model.size() > 0) begin
                m = (model.size() < DEQ_WIDTH) ? model.size() : DEQ_WIDTH;
                repeat (m) void'(model.pop_front());
            end
            if (ready) begin
                for (int i = 0; i < ENQ_WIDTH; i++) begin
                    if (mask[i]) model.push_back(sent[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.enq_valid_in         = '0;
        bus.q_increment_ready_in = 1'b0;
        flush                    = 1'b0;
    endtask

    task automatic checkLanes(string tag);
        logic [DEQ_WIDTH-1:0] expLanes;
        expLanes = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) expLanes[i] = (i < model.size());
        checkOutput({tag, ".count"}, 128'(bus.count_out), 128'(model.size()));
        checkOutput({tag, ".q_valid"}, 128'(bus.q_valid_out), 128'(model.size() != 0));
        checkOutput({tag, ".enq_ready"}, 128'(bus.enq_ready_out), 128'((DEPTH - model.size()) >= ENQ_WIDTH));
        checkOutput({tag, ".lane_valid"}, 128'(bus.q_lane_valid_out), 128'(expLanes));
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            if (i < model.size()) begin
                checkOutput($sformatf("%s.lane%0d", tag, i),
                            bus.q_uops_out[i*UOP_BITS +: UOP_BITS], model[i]);
            end
        end
    endtask

    initial begin
        bus.enq_valid_in         = '0;
        bus.enq_uops_in          = '0;
        bus.q_increment_ready_in = 1'b0;

        #1 rst = 1'b1;
        #1;
        checkOutput("reset.count", 128'(bus.count_out), 128'd0);
        checkOutput("reset.q_valid", 128'(bus.q_valid_out), 128'd0);
        checkOutput("reset.enq_ready", 128'(bus.enq_ready_out), 128'd1);
        checkOutput("reset.lane_valid", 128'(bus.q_lane_valid_out), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Holes in the valid mask compact into consecutive entries.
        applyStimulus(4'b1010, 1'b0, 1'b0);
        savedA = sent[1];
        savedB = sent[3];
        checkOutput("compact.lane_valid", 128'(bus.q_lane_valid_out), 128'b0011);
        checkOutput("compact.lane0", bus.q_uops_out[0 +: UOP_BITS], savedA);
        checkOutput("compact.lane1", bus.q_uops_out[UOP_BITS +: UOP_BITS], savedB);
        checkOutput("compact.count", 128'(bus.count_out), 128'd2);

        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("partial.count", 128'(bus.count_out), 128'd0);
        checkOutput("partial.q_valid", 128'(bus.q_valid_out), 128'd0);

        // Fill to the brim, then show the full queue refuses more.
        repeat (3) applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("fill12.count", 128'(bus.count_out), 128'd12);
        checkOutput("fill12.enq_ready", 128'(bus.enq_ready_out), 128'd1);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("fill16.count", 128'(bus.count_out), 128'd16);
        checkOutput("fill16.enq_ready", 128'(bus.enq_ready_out), 128'd0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("overflow.count", 128'(bus.count_out), 128'd16);
        checkLanes("full");
        for (int g = 0; g < 4; g++) begin
            applyStimulus(4'h0, 1'b1, 1'b0);
            checkLanes($sformatf("drain%0d", g));
        end

        // Walk head to 14, then straddle the wrap with six entries (indices 14..3).
        repeat (3) applyStimulus(4'hF, 1'b0, 1'b0);
        repeat (3) applyStimulus(4'h0, 1'b1, 1'b0);
        checkOutput("wrapsetup.count", 128'(bus.count_out), 128'd0);
        applyStimulus(4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        savedA = sent[0];
        checkLanes("wrap6");
        applyStimulus(4'hF, 1'b1, 1'b0);
        checkOutput("concurrent.count", 128'(bus.count_out), 128'd6);
        checkOutput("concurrent.lane0", bus.q_uops_out[0 +: UOP_BITS], savedA);
        checkLanes("concurrent");
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkLanes("wrapdrain0");
        applyStimulus(4'h0, 1'b1, 1'b0);
        checkLanes("wrapdrain1");

        // Flush beats a simultaneous enqueue and dequeue.
        repeat (2) applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("preflush.count", 128'(bus.count_out), 128'd8);
        applyStimulus(4'hF, 1'b1, 1'b1);
        checkOutput("flush.count", 128'(bus.count_out), 128'd0);
        checkOutput("flush.q_valid", 128'(bus.q_valid_out), 128'd0);
        checkOutput("flush.enq_ready", 128'(bus.enq_ready_out), 128'd1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        savedB = sent[0];
        checkOutput("postflush.count", 128'(bus.count_out), 128'd1);
        checkOutput("postflush.lane0", bus.q_uops_out[0 +: UOP_BITS], savedB);

        // Asynchronous reset in the middle of a cycle, with traffic in flight.
        applyStimulus(4'hF, 1'b0, 1'b0);
        checkOutput("premidreset.count", 128'(bus.count_out), 128'd5);
        bus.enq_valid_in = 4'hF;
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset.count", 128'(bus.count_out), 128'd0);
        checkOutput("midreset.q_valid", 128'(bus.q_valid_out), 128'd0);
        checkOutput("midreset.enq_ready", 128'(bus.enq_ready_out), 128'd1);
        bus.enq_valid_in = '0;
        model.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(4'b0100, 1'b0, 1'b0);
        savedA = sent[2];
        checkOutput("afterreset.count", 128'(bus.count_out), 128'd1);
        checkOutput("afterreset.lane0", bus.q_uops_out[0 +: UOP_BITS], savedA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
